count_nb: RTL and testbench

COUNT_NB -- requirements
Module: count_nb

---
 rtl/count_pkg.sv | 18 +
 rtl/count_tick_gen.sv | 33 +++
 rtl/count_nb.sv | 81 ++++++++
 tb/tb_count_nb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared constants for the count_nb up/down counter.
// Default width, prescale limits and direction encoding.
package count_pkg;

  localparam int DEF_WIDTH = 8;

  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 65535;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Phase register width for a given prescale ratio.
  function automatic int phase_bits(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/count_tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles.
// restart discards the partial phase.
module count_tick_gen
  import count_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = phase_bits(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en && (phase == LAST);

  // Phase advances only on enabled cycles and wraps on a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/count_nb.sv
// Prescaled up/down counter with wrap and terminal-count pulse.
// Define COUNT_NB_SAT_EN to add the sat (saturate) input.
module count_nb
  import count_pkg::*;
#(
  parameter int              WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`ifdef COUNT_NB_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  logic             tick;
  logic             restart;
  logic             sat_on;
  logic             at_end;
  logic [WIDTH-1:0] load_v;
  logic [WIDTH-1:0] step_v;

  assign restart = clr | load;

`ifdef COUNT_NB_SAT_EN
  assign sat_on = sat;
`else
  assign sat_on = 1'b0;
`endif

  count_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(restart),
    .tick   (tick)
  );

  // Next value for a load (clamped) and for a tick (wrap or hold).
  always_comb begin
    load_v = (din > MAX) ? MAX : din;
    at_end = (up == UP) ? (out == MAX) : (out == '0);
    if (at_end) begin
      if (sat_on)
        step_v = out;
      else
        step_v = (up == UP) ? '0 : MAX;
    end else begin
      step_v = (up == UP) ? out + 1'b1 : out - 1'b1;
    end
  end

  // Value and tc registers; clr beats load beats step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      tc  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        out <= '0;
      end else if (load) begin
        out <= load_v;
      end else if (tick) begin
        out <= step_v;
        tc  <= at_end;
      end
    end
  end

endmodule

// File: tb/tb_count_nb.sv
// Bench for count_nb: three parameterisations share one stimulus.
// Vector table, directed corner sequences and a random run.
module tb_count_nb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en, up, clr, load, sat;
  logic [7:0] din;
  logic [7:0] o0, o1, o2;
  logic       t0, t1, t2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_nb #(.WIDTH(8)) d0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .din(din),
`ifdef COUNT_NB_SAT_EN
    .sat(sat),
`endif
    .out(o0), .tc(t0)
  );

  count_nb #(.WIDTH(8), .MAX(8'd9), .PRESCALE(4)) d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .din(din),
`ifdef COUNT_NB_SAT_EN
    .sat(sat),
`endif
    .out(o1), .tc(t1)
  );

  count_nb #(.WIDTH(8), .MAX(8'd150), .PRESCALE(3)) d2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .din(din),
`ifdef COUNT_NB_SAT_EN
    .sat(sat),
`endif
    .out(o2), .tc(t2)
  );

  typedef struct {
    int v;
    int ph;
    bit tc;
  } ms_t;

  ms_t m[3];
  int  mx[3] = '{255, 9, 150};
  int  pr[3] = '{1, 4, 3};

  typedef struct {
    bit       en;
    bit       up;
    bit       clr;
    bit       load;
    bit [7:0] din;
    int       eo;
    bit       et;
  } vec_t;

  vec_t tbl[19];

  function automatic bit sat_eff();
`ifdef COUNT_NB_SAT_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: count enables modulo PRESCALE, value modulo MAX+1.
  function automatic ms_t mstep(ms_t s, int maxv, int pres, bit e, bit u,
                                bit c, bit l, int d, bit st);
    ms_t n;
    bit  wrap;
    n = s;
    n.tc = 1'b0;
    if (c) begin
      n.v = 0;
      n.ph = 0;
    end else if (l) begin
      n.v = (d > maxv) ? maxv : d;
      n.ph = 0;
    end else if (e) begin
      n.ph = (s.ph + 1) % pres;
      if (n.ph == 0) begin
        wrap = u ? (s.v == maxv) : (s.v == 0);
        if (wrap && st)
          n.v = s.v;
        else if (u)
          n.v = (s.v + 1) % (maxv + 1);
        else
          n.v = (s.v + maxv) % (maxv + 1);
        n.tc = wrap;
      end
    end
    return n;
  endfunction

  function automatic logic [8:0] dout(int i);
    case (i)
      0: return {t0, o0};
      1: return {t1, o1};
      default: return {t2, o2};
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all();
    for (int i = 0; i < 3; i++) begin
      logic [8:0] q;
      q = dout(i);
      chk($sformatf("d%0d_out", i), {24'd0, q[7:0]}, m[i].v);
      chk($sformatf("d%0d_tc", i), {31'd0, q[8]}, {31'd0, m[i].tc});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 1'b0};
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = mstep(m[i], mx[i], pr[i], en, up, clr, load, int'(din),
                   sat_eff());
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    en = 0; up = 1; clr = 0; load = 0; din = 0; sat = 0;

    tbl = '{
      '{1'b0, 1'b1, 1'b0, 1'b1, 8'd200, 150, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 8'd5,   0,   1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 8'd149, 149, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   149, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   149, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   149, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   150, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   150, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   150, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   0,   1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   0,   1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   150, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b1, 8'd7,   7,   1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   0,   1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0,   1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   0,   1'b0}
    };

    // power-on reset, held across the first edge
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_o0", {24'd0, o0}, 0);
    chk("rst_t0", {31'd0, t0}, 0);
    chk_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // full up-count wrap on the default instance
    en = 1; up = 1;
    repeat (255) cyc();
    chk("wrap_255", {24'd0, o0}, 255);
    chk("wrap_pre_tc", {31'd0, t0}, 0);
    cyc();
    chk("wrap_0", {24'd0, o0}, 0);
    chk("wrap_tc", {31'd0, t0}, 1);
    cyc();
    chk("wrap_tc_once", {31'd0, t0}, 0);
    chk("wrap_1", {24'd0, o0}, 1);

    // down-count with prescale 4 and MAX 9
    en = 0;
    do_reset();
    en = 1; up = 0;
    repeat (3) cyc();
    chk("p4_hold", {24'd0, o1}, 0);
    cyc();
    chk("p4_to9", {24'd0, o1}, 9);
    chk("p4_tc", {31'd0, t1}, 1);
    repeat (3) cyc();
    chk("p4_stay9", {24'd0, o1}, 9);
    chk("p4_tc_low", {31'd0, t1}, 0);
    cyc();
    chk("p4_to8", {24'd0, o1}, 8);
    chk("p4_tc_no", {31'd0, t1}, 0);

    // vector table on the MAX=150 / prescale 3 instance
    en = 0;
    do_reset();
    foreach (tbl[k]) begin
      en = tbl[k].en; up = tbl[k].up; clr = tbl[k].clr;
      load = tbl[k].load; din = tbl[k].din;
      cyc();
      chk($sformatf("vec%0d_out", k), {24'd0, o2}, tbl[k].eo);
      chk($sformatf("vec%0d_tc", k), {31'd0, t2}, {31'd0, tbl[k].et});
    end
    en = 0; clr = 0; load = 0;

    // async reset mid-prescale discards the partial phase
    do_reset();
    load = 1; din = 8'd77;
    cyc();
    load = 0; en = 1; up = 1;
    repeat (2) cyc();
    chk("mid_77", {24'd0, o2}, 77);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {24'd0, o2}, 0);
    chk("mid_rst_tc", {31'd0, t2}, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) cyc();
    chk("mid_no_tick", {24'd0, o2}, 0);
    cyc();
    chk("mid_tick", {24'd0, o2}, 1);

`ifdef COUNT_NB_SAT_EN
    // saturating up-count holds at MAX and keeps pulsing tc
    en = 0;
    do_reset();
    sat = 1; load = 1; din = 8'd253;
    cyc();
    load = 0; en = 1; up = 1;
    cyc();
    chk("sat_254", {24'd0, o0}, 254);
    cyc();
    chk("sat_255", {24'd0, o0}, 255);
    chk("sat_tc0", {31'd0, t0}, 0);
    cyc();
    chk("sat_hold1", {24'd0, o0}, 255);
    chk("sat_tc1", {31'd0, t0}, 1);
    cyc();
    chk("sat_hold2", {24'd0, o0}, 255);
    chk("sat_tc2", {31'd0, t0}, 1);
    sat = 0;
`endif

    // random traffic against the reference model
    en = 0;
    do_reset();
    repeat (800) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom);
      clr  = ($urandom_range(0, 24) == 0);
      load = ($urandom_range(0, 14) == 0);
      din  = 8'($urandom);
      sat  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk_all();
        rst = 1'b0;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
